// File: rtl/alu_pkg.sv
// Shared types and constants for the arbitrated 12-bit ALU.
package alu_pkg;

  localparam int ALU_DW   = 12;
  localparam int ALU_NREQ = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_CMP = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Encodings 000 and 111 have no operation behind them.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the response consumer and alu_arbiter.
interface alu_arbiter_if #(
  parameter int DW   = alu_pkg::ALU_DW,
  parameter int NREQ = alu_pkg::ALU_NREQ
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][2:0]    req_op;
  logic [NREQ-1:0][DW-1:0] req_a;
  logic [NREQ-1:0][DW-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [DW-1:0]           rsp_result;
  logic                    rsp_zero;
  logic                    rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/CMP, result modulo 2^DW, zero only for CMP.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic [DW-1:0] src_a_i,
  input  logic [DW-1:0] src_b_i,
  input  logic [2:0]    control_i,
  output logic [DW-1:0] result_o,
  output logic          zero_o
);

  always_comb begin
    result_o = '0;
    zero_o   = 1'b0;
    case (control_i)
      OP_ADD: result_o = src_a_i + src_b_i;
      OP_SUB: result_o = src_a_i - src_b_i;
      OP_AND: result_o = src_a_i & src_b_i;
      OP_OR:  result_o = src_a_i | src_b_i;
      OP_XOR: result_o = src_a_i ^ src_b_i;
      OP_CMP: begin
        result_o = src_a_i - src_b_i;
        zero_o   = (src_a_i == src_b_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; IDLE -> EXEC -> RESP per op.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int NREQ = ALU_NREQ
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  arb_state_t    state_q, state_d;
  logic          prio_q;
  logic          id_q;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q;

  logic          rsp_id_q, rsp_zero_q, rsp_err_q;
  logic [DW-1:0] rsp_result_q;

  logic          gnt_id;
  logic          grant_en;
  logic [DW-1:0] alu_result;
  logic          alu_zero;

  // prio only breaks ties; a lone requester wins regardless of it.
  always_comb begin
    gnt_id = 1'b0;
    if (bus.req_valid[0] && bus.req_valid[1]) begin
      gnt_id = prio_q;
    end else if (bus.req_valid[1]) begin
      gnt_id = 1'b1;
    end
  end

  assign grant_en = (state_q == IDLE) && !reset && (|bus.req_valid);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = grant_en && (gnt_id == 1'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_en) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (grant_en) begin
        id_q   <= gnt_id;
        op_q   <= bus.req_op[gnt_id];
        a_q    <= bus.req_a[gnt_id];
        b_q    <= bus.req_b[gnt_id];
        prio_q <= ~gnt_id;
      end
      // Response registers only move in EXEC, so they hold through RESP backpressure.
      if (state_q == EXEC) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_err_q    <= op_is_illegal(op_q);
      end
    end
  end

  alu_arbiter_alu #(.DW(DW)) u_alu (
    .src_a_i   (a_q),
    .src_b_i   (b_q),
    .control_i (op_q),
    .result_o  (alu_result),
    .zero_o    (alu_zero)
  );

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: single ops, contention, backpressure, reset.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(12), .NREQ(2)) bus ();

  alu_arbiter #(.DW(12), .NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive(input int r, input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
    bus.req_op[r] = op;
    bus.req_a[r]  = a;
    bus.req_b[r]  = b;
  endtask

  // Entered at the start of an IDLE cycle; leaves at the start of the next IDLE cycle.
  task automatic run_single(input string tag, input int r, input logic [2:0] op,
                            input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] exp_res, input logic exp_zero, input logic exp_err);
    drive(r, op, a, b);
    bus.req_valid    = 2'b00;
    bus.req_valid[r] = 1'b1;
    bus.rsp_ready    = 1'b0;
    settle;
    chk({tag, "_ready"}, 32'(bus.req_ready), (r == 0) ? 32'h1 : 32'h2);
    tick;
    bus.req_valid = 2'b00;
    settle;
    chk({tag, "_exec_novalid"}, 32'(bus.rsp_valid), 32'h0);
    tick;
    settle;
    chk({tag, "_valid"},  32'(bus.rsp_valid),  32'h1);
    chk({tag, "_result"}, 32'(bus.rsp_result), 32'(exp_res));
    chk({tag, "_id"},     32'(bus.rsp_id),     32'(r));
    chk({tag, "_zero"},   32'(bus.rsp_zero),   32'(exp_zero));
    chk({tag, "_err"},    32'(bus.rsp_err),    32'(exp_err));
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    tick;
    tick;

    // Reset state, and no grant while reset is high even with both valid.
    bus.req_valid = 2'b11;
    settle;
    chk("rst_no_grant",  32'(bus.req_ready),  32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid),  32'h0);
    chk("rst_result",    32'(bus.rsp_result), 32'h0);
    chk("rst_id",        32'(bus.rsp_id),     32'h0);
    chk("rst_zero",      32'(bus.rsp_zero),   32'h0);
    chk("rst_err",       32'(bus.rsp_err),    32'h0);
    tick;
    reset         = 1'b0;
    bus.req_valid = 2'b00;

    run_single("add",      0, 3'b001, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b0);
    run_single("sub_wrap", 1, 3'b010, 12'h000, 12'h001, 12'hFFF, 1'b0, 1'b0);
    run_single("cmp_eq",   0, 3'b110, 12'h123, 12'h123, 12'h000, 1'b1, 1'b0);
    run_single("cmp_ne",   0, 3'b110, 12'h124, 12'h123, 12'h001, 1'b0, 1'b0);
    run_single("ill7",     1, 3'b111, 12'hABC, 12'h001, 12'h000, 1'b0, 1'b1);
    run_single("and",      1, 3'b011, 12'hF0F, 12'h0FF, 12'h00F, 1'b0, 1'b0);
    run_single("ill0",     0, 3'b000, 12'hABC, 12'hABC, 12'h000, 1'b0, 1'b1);
    run_single("or",       0, 3'b100, 12'h800, 12'h001, 12'h801, 1'b0, 1'b0);

    // Contention from a fresh reset: grants alternate 0,1,0,1.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(0, 3'b010, 12'h005, 12'h007);
    drive(1, 3'b101, 12'hF0F, 12'h0FF);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle;
      chk($sformatf("rr%0d_ready", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick;
      settle;
      chk($sformatf("rr%0d_exec_ready", k), 32'(bus.req_ready), 32'h0);
      tick;
      settle;
      chk($sformatf("rr%0d_valid", k),  32'(bus.rsp_valid),  32'h1);
      chk($sformatf("rr%0d_id", k),     32'(bus.rsp_id),     32'(k % 2));
      chk($sformatf("rr%0d_result", k), 32'(bus.rsp_result), (k % 2 == 0) ? 32'hFFE : 32'hFF0);
      tick;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;

    // Backpressure: response held 5 cycles while req1 waits.
    drive(0, 3'b001, 12'h001, 12'h002);
    drive(1, 3'b100, 12'h0F0, 12'h00F);
    bus.req_valid = 2'b01;
    settle;
    chk("bp_grant0", 32'(bus.req_ready), 32'h1);
    tick;
    bus.req_valid = 2'b10;
    settle;
    chk("bp_exec_ready", 32'(bus.req_ready), 32'h0);
    tick;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk($sformatf("bp%0d_valid", k),  32'(bus.rsp_valid),  32'h1);
      chk($sformatf("bp%0d_result", k), 32'(bus.rsp_result), 32'h003);
      chk($sformatf("bp%0d_id", k),     32'(bus.rsp_id),     32'h0);
      chk($sformatf("bp%0d_ready", k),  32'(bus.req_ready),  32'h0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    settle;
    chk("bp_hs_ready", 32'(bus.req_ready), 32'h0);
    tick;
    bus.rsp_ready = 1'b0;
    settle;
    chk("bp_grant1", 32'(bus.req_ready), 32'h2);
    tick;
    bus.req_valid = 2'b00;
    tick;
    settle;
    chk("bp_r1_valid",  32'(bus.rsp_valid),  32'h1);
    chk("bp_r1_result", 32'(bus.rsp_result), 32'h0FF);
    chk("bp_r1_id",     32'(bus.rsp_id),     32'h1);
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;

    // Reset during EXEC: op discarded, prio back to 0.
    drive(0, 3'b001, 12'h100, 12'h100);
    bus.req_valid = 2'b01;
    settle;
    chk("rx_grant0", 32'(bus.req_ready), 32'h1);
    tick;
    bus.req_valid = 2'b10;
    reset         = 1'b1;
    settle;
    chk("rx_rst_ready", 32'(bus.req_ready), 32'h0);
    tick;
    reset = 1'b0;
    drive(0, 3'b101, 12'hAAA, 12'h555);
    bus.req_valid = 2'b11;
    settle;
    chk("rx_no_rsp",    32'(bus.rsp_valid),  32'h0);
    chk("rx_result_clr", 32'(bus.rsp_result), 32'h0);
    chk("rx_prio0",     32'(bus.req_ready),  32'h1);
    tick;
    bus.req_valid = 2'b00;
    settle;
    chk("rx_exec_novalid", 32'(bus.rsp_valid), 32'h0);
    tick;
    settle;
    chk("rx_valid",  32'(bus.rsp_valid),  32'h1);
    chk("rx_result", 32'(bus.rsp_result), 32'hFFF);
    chk("rx_id",     32'(bus.rsp_id),     32'h0);
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    settle;
    chk("rx_done_idle", 32'(bus.rsp_valid), 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 12-bit ALU between two requesters (e.g. issue stage and address-generation unit). The block arbitrates round-robin, latches the winner's operands and opcode, and runs one ALU operation. It returns a registered result and flags to a single response port, tagged with the requester ID. Each transaction takes three cycles; the ALU instance sits inside this block.

## Interface
Parameters:
- DW, 12, operand/result width.
- NREQ, 2, number of requesters (fixed at 2 in this revision).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [NREQ]  requester i presents an operation.
- req_ready  out  [NREQ]  request accepted this cycle (one-hot or zero).
- req_op  in  [NREQ][3]  opcode per requester (alu_op_t).
- req_a  in  [NREQ][DW]  operand A per requester.
- req_b  in  [NREQ][DW]  operand B per requester.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  index of requester that issued the op.
- rsp_result  out  DW  ALU result.
- rsp_zero  out  1  compare-equal flag; set only for CMP.
- rsp_err  out  1  opcode was 000 or 111.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid, grant one requester, assert its req_ready, latch op/a/b/id, go to EXEC. Otherwise stay in IDLE.
  - EXEC: ALU evaluates the latched operands. Register result, zero and err. Go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Grant rule:
  - Only one requester valid: that requester wins.
  - Both valid: the requester named by the priority pointer `prio` wins.
  - After each grant, `prio` points to the other requester.
  - `prio` changes only when a grant occurs.
- req_ready[i] = (state==IDLE) && req_valid[i] && granted(i). It depends combinationally on req_valid. It is never high outside IDLE.
- Opcodes (alu_op_t):
  - 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR: zero=0.
  - 110 CMP: result = A−B, zero = (A==B).
  - 000 and 111: result 0, zero 0, rsp_err=1.
- Arithmetic is modulo 2^DW. There is no carry or overflow output; 0x000−0x001 = 0xFFF.
- Requesters must hold req_valid, req_op, req_a and req_b stable until req_ready. Dropping req_valid early is allowed and simply withdraws the request.
- rsp_* are stable while rsp_valid && !rsp_ready.

## Timing
- Reset values:
  - state=IDLE, prio=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - req_ready=0 while reset is high.
- Latency: handshake in cycle N; rsp_valid rises in cycle N+2.
- Throughput: best case one op per 3 cycles. The earliest next grant is the cycle after the rsp handshake; IDLE is never skipped.
- Backpressure: RESP holds indefinitely. Pending requests wait with req_ready=0.
- Reset asserted in EXEC or RESP: the in-flight op is discarded with no response. Next cycle: IDLE, prio=0.
- Reset and req_valid in the same cycle: no grant.
- A requester that is valid continuously is served at least every second grant when contended.

## Structure
- Shared package alu_pkg:
  - alu_op_t enum (ADD=3'b001 … CMP=3'b110).
  - ALU_DW=12.
  - arb_state_t {IDLE, EXEC, RESP}.
- One sub-module: the existing ALU combinational unit, instantiated once.
  - SrcA/SrcB/Control_in are driven from the latched registers.
  - Its outputs are registered in EXEC.
- The err flag is derived from the latched opcode, not from the ALU.

## Test plan
- Single ADD: req0 op=001 a=0x7FF b=0x001 → req_ready[0] at N; at N+2 rsp_valid, rsp_result=0x800, rsp_id=0, zero=0, err=0.
- Contention: both valid continuously from reset, req0 SUB 0x005−0x007, req1 XOR 0xF0F^0x0FF → grant order 0,1,0,1. Results 0xFFE (id 0) and 0xFF0 (id 1).
- CMP: a=b=0x123 → result 0x000, zero=1. Then a=0x124, b=0x123 → result 0x001, zero=0.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending → rsp_* stable, req_ready=0 throughout. req1 is granted the cycle after the rsp handshake.
- Illegal opcode: op=111 a=0xABC → result 0, zero 0, err=1. The next legal op has err=0.
- Reset in EXEC with req1 pending → no rsp_valid. After reset, with both requesters valid, req0 is granted first.
